// File: rtl/uart_cmd_responder.sv
// UART command endpoint: receives 8N1 command frames, serves reads and writes
// against four 32-bit registers, and transmits the reply bytes back-to-back.
module uart_cmd_responder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  output logic [2:0]  state,
  output logic [31:0] reg0,
  output logic        cmd_done,
  output logic        frame_err
);
  localparam int CW        = $clog2(CLKS_PER_BIT);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_M2  = CW'(CLKS_PER_BIT - 2);
  localparam logic [TW-1:0] TO_M1   = TW'(TO_CYCLES - 1);
  localparam logic [7:0]    ACK     = 8'hA5;
  localparam logic [7:0]    NAK     = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_RXDATA = 3'b001,
    S_WRITE  = 3'b010,
    S_TXRESP = 3'b011,
    S_DRAIN  = 3'b100
  } state_t;

  logic          rx_meta_r, rx_sync_r;
  logic          rx_busy_r, rx_strobe_r, frame_err_r;
  logic [CW-1:0] rx_cnt_r;
  logic [3:0]    rx_idx_r;
  logic [7:0]    rx_shift_r;

  state_t        state_r, next_state_s;
  logic [1:0]    idx_r, byte_cnt_r;
  logic [31:0]   asm_r;
  logic [TW-1:0] timer_r;
  logic [31:0]   regs_r [4];
  logic [31:0]   resp_r;
  logic [1:0]    resp_last_r;

  logic          load_resp_s, start_write_s, take_byte_s, do_write_s;
  logic [31:0]   resp_word_s;
  logic [1:0]    resp_last_s;

  logic          tx_r, tx_active_r, cmd_done_r;
  logic [CW-1:0] tx_cnt_r;
  logic [3:0]    tx_bit_r;
  logic [7:0]    tx_shift_r;
  logic [31:0]   tx_word_r;
  logic [1:0]    tx_left_r;

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver: bit index 0 is the start bit, 1..8 data, 9 the stop bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_busy_r   <= 1'b0;
      rx_cnt_r    <= '0;
      rx_idx_r    <= 4'd0;
      rx_shift_r  <= 8'h00;
      rx_strobe_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_strobe_r <= 1'b0;
      frame_err_r <= 1'b0;
      if (!rx_busy_r) begin
        if (!rx_sync_r) begin
          rx_busy_r <= 1'b1;
          rx_cnt_r  <= '0;
          rx_idx_r  <= 4'd0;
        end
      end else if (rx_idx_r == 4'd0) begin
        if (rx_cnt_r == HALF_M1) begin
          rx_cnt_r <= '0;
          if (rx_sync_r) rx_busy_r <= 1'b0;
          else           rx_idx_r  <= 4'd1;
        end else begin
          rx_cnt_r <= rx_cnt_r + CW'(1);
        end
      end else if (rx_cnt_r == BIT_M1) begin
        rx_cnt_r <= '0;
        if (rx_idx_r == 4'd9) begin
          rx_busy_r <= 1'b0;
          if (rx_sync_r) rx_strobe_r <= 1'b1;
          else           frame_err_r <= 1'b1;
        end else begin
          rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
          rx_idx_r   <= rx_idx_r + 4'd1;
        end
      end else begin
        rx_cnt_r <= rx_cnt_r + CW'(1);
      end
    end
  end

  // Command FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= next_state_s;
  end

  // Command FSM next-state and datapath controls.
  always_comb begin
    next_state_s  = state_r;
    load_resp_s   = 1'b0;
    resp_word_s   = 32'h0000_0000;
    resp_last_s   = 2'd0;
    start_write_s = 1'b0;
    take_byte_s   = 1'b0;
    do_write_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (rx_strobe_r) begin
          if (rx_shift_r[6:2] != 5'd0) begin
            load_resp_s  = 1'b1;
            resp_word_s  = {24'h00_0000, NAK};
            next_state_s = S_TXRESP;
          end else if (rx_shift_r[7]) begin
            start_write_s = 1'b1;
            next_state_s  = S_RXDATA;
          end else begin
            load_resp_s  = 1'b1;
            resp_word_s  = regs_r[rx_shift_r[1:0]];
            resp_last_s  = 2'd3;
            next_state_s = S_TXRESP;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_RXDATA: begin
        // A strobe on the expiry cycle still counts as an accepted byte.
        if (rx_strobe_r) begin
          take_byte_s = 1'b1;
          if (byte_cnt_r == 2'd3) next_state_s = S_WRITE;
          else                    next_state_s = S_RXDATA;
        end else if (frame_err_r || (timer_r == TO_M1)) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_RXDATA;
        end
      end
      S_WRITE: begin
        do_write_s   = 1'b1;
        load_resp_s  = 1'b1;
        resp_word_s  = {24'h00_0000, ACK};
        next_state_s = S_TXRESP;
      end
      S_TXRESP: begin
        if (cmd_done_r) next_state_s = S_DRAIN;
        else            next_state_s = S_TXRESP;
      end
      S_DRAIN: next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Write assembly, inter-byte timer, register file and reply buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_r       <= 2'd0;
      byte_cnt_r  <= 2'd0;
      asm_r       <= 32'h0000_0000;
      timer_r     <= '0;
      resp_r      <= 32'h0000_0000;
      resp_last_r <= 2'd0;
      for (int i = 0; i < 4; i++) regs_r[i] <= 32'h0000_0000;
    end else begin
      if (start_write_s) begin
        idx_r      <= rx_shift_r[1:0];
        byte_cnt_r <= 2'd0;
        timer_r    <= '0;
      end else if (take_byte_s) begin
        asm_r      <= {rx_shift_r, asm_r[31:8]};
        byte_cnt_r <= byte_cnt_r + 2'd1;
        timer_r    <= '0;
      end else if (state_r == S_RXDATA) begin
        timer_r <= timer_r + TW'(1);
      end
      if (do_write_s) regs_r[idx_r] <= asm_r;
      if (load_resp_s) begin
        resp_r      <= resp_word_s;
        resp_last_r <= resp_last_s;
      end
    end
  end

  // Transmitter; cmd_done is registered one cycle early so it lands on the
  // final cycle of the last stop bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_r        <= 1'b1;
      tx_active_r <= 1'b0;
      tx_cnt_r    <= '0;
      tx_bit_r    <= 4'd0;
      tx_shift_r  <= 8'h00;
      tx_word_r   <= 32'h0000_0000;
      tx_left_r   <= 2'd0;
      cmd_done_r  <= 1'b0;
    end else if (state_r != S_TXRESP) begin
      tx_r        <= 1'b1;
      tx_active_r <= 1'b0;
      cmd_done_r  <= 1'b0;
    end else if (!tx_active_r) begin
      tx_active_r <= 1'b1;
      tx_r        <= 1'b0;
      tx_cnt_r    <= '0;
      tx_bit_r    <= 4'd0;
      tx_shift_r  <= resp_r[7:0];
      tx_word_r   <= {8'h00, resp_r[31:8]};
      tx_left_r   <= resp_last_r;
      cmd_done_r  <= 1'b0;
    end else begin
      cmd_done_r <= (tx_bit_r == 4'd9) && (tx_cnt_r == BIT_M2) && (tx_left_r == 2'd0);
      if (tx_cnt_r != BIT_M1) begin
        tx_cnt_r <= tx_cnt_r + CW'(1);
      end else begin
        tx_cnt_r <= '0;
        if (tx_bit_r == 4'd9) begin
          if (tx_left_r != 2'd0) begin
            tx_r       <= 1'b0;
            tx_bit_r   <= 4'd0;
            tx_shift_r <= tx_word_r[7:0];
            tx_word_r  <= {8'h00, tx_word_r[31:8]};
            tx_left_r  <= tx_left_r - 2'd1;
          end else begin
            tx_r        <= 1'b1;
            tx_active_r <= 1'b0;
          end
        end else if (tx_bit_r == 4'd8) begin
          tx_r     <= 1'b1;
          tx_bit_r <= 4'd9;
        end else begin
          tx_r       <= tx_shift_r[0];
          tx_shift_r <= {1'b0, tx_shift_r[7:1]};
          tx_bit_r   <= tx_bit_r + 4'd1;
        end
      end
    end
  end

  assign tx        = tx_r;
  assign state     = state_r;
  assign reg0      = regs_r[0];
  assign cmd_done  = cmd_done_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: commands push expected reply bytes,
// an independent UART decoder on tx pops and compares them.
module tb_uart_cmd_responder;
  localparam int CPB   = 8;
  localparam int TOB   = 40;
  localparam int CLK_P = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic        tx;
  logic [2:0]  state;
  logic [31:0] reg0;
  logic        cmd_done, frame_err;

  int n_checks = 0, n_fail = 0;
  int rst_epoch = 0, done_cnt = 0, ferr_cnt = 0, exp_done = 0;
  logic [7:0]  exp_q [$];
  logic [31:0] model [4];

  uart_cmd_responder #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clock(clock), .reset(reset), .rx(rx), .tx(tx), .state(state),
    .reg0(reg0), .cmd_done(cmd_done), .frame_err(frame_err)
  );

  always #(CLK_P/2) clock = ~clock;

  always @(posedge clock) if (reset) rst_epoch <= rst_epoch + 1;

  always @(negedge clock) begin
    if (cmd_done)  done_cnt <= done_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent UART decoder on tx; frames cut by a reset are discarded.
  initial begin : tx_monitor
    logic [7:0] b;
    logic st, sp;
    int e0;
    forever begin
      @(negedge tx);
      e0 = rst_epoch;
      #(CPB*CLK_P/2 + CLK_P/2);
      st = tx;
      for (int i = 0; i < 8; i++) begin
        #(CPB*CLK_P);
        b[i] = tx;
      end
      #(CPB*CLK_P);
      sp = tx;
      if (rst_epoch == e0) begin
        check("tx_start_bit", st, 1'b0);
        check("tx_stop_bit", sp, 1'b1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got byte %02h expected none", b);
        end else begin
          check("tx_byte", b, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    @(negedge clock);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = good_stop;
    if (good_stop) begin
      @(negedge clock);
    end else begin
      repeat (CPB) @(negedge clock);
      rx = 1'b1;
    end
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] d, output int nbytes);
    logic [31:0] w;
    if (c[6:2] != 5'd0) begin
      exp_q.push_back(8'h5A);
      nbytes = 1;
      send_byte(c, 1'b1);
    end else if (c[7]) begin
      model[c[1:0]] = d;
      exp_q.push_back(8'hA5);
      nbytes = 1;
      send_byte(c, 1'b1);
      for (int i = 0; i < 4; i++) begin
        repeat (CPB) @(negedge clock);
        send_byte(d[8*i +: 8], 1'b1);
      end
    end else begin
      w = model[c[1:0]];
      for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
      nbytes = 4;
      send_byte(c, 1'b1);
    end
  endtask

  task automatic wait_done(input int nbytes);
    int t_fall;
    bit got;
    logic [2:0] prev;
    t_fall = -1;
    got = 1'b0;
    prev = 3'b000;
    for (int cyc = 0; cyc < (nbytes*10 + 60)*CPB && !got; cyc++) begin
      @(negedge clock);
      if (prev == 3'b010) check("reg0_after_write", reg0, model[0]);
      prev = state;
      if (tx === 1'b0 && t_fall < 0) t_fall = cyc;
      if (cmd_done === 1'b1) begin
        got = 1'b1;
        check("reply_duration", cyc - t_fall, nbytes*10*CPB - 1);
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_done_timeout: got no pulse expected one");
    end else begin
      exp_done++;
    end
    repeat (2) @(negedge clock);
    check("state_idle_after_reply", state, 3'b000);
    check("tx_idle_after_reply", tx, 1'b1);
  endtask

  task automatic run_cmd(input logic [7:0] c, input logic [31:0] d);
    int n;
    send_cmd(c, d, n);
    wait_done(n);
  endtask

  initial begin
    #(80000*CLK_P);
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n, f0;
    logic [7:0] c;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;

    // Reset and first read
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_tx", tx, 1'b1);
    check("reset_state", state, 3'b000);
    check("reset_reg0", reg0, 32'h0);
    check("reset_cmd_done", cmd_done, 1'b0);
    reset = 1'b0;
    run_cmd(8'h00, 32'h0);

    // Write then read, write reg0
    run_cmd(8'h81, 32'hDEADBEEF);
    run_cmd(8'h01, 32'h0);
    run_cmd(8'h80, 32'h11223344);
    check("reg0_value", reg0, 32'h11223344);

    // Invalid command
    run_cmd(8'h04, 32'h0);
    run_cmd(8'h01, 32'h0);

    // Inter-byte timeout
    send_byte(8'h82, 1'b1);
    repeat (CPB) @(negedge clock);
    send_byte(8'h01, 1'b1);
    repeat (CPB-1) @(negedge clock);
    check("timeout_rxdata", state, 3'b001);
    repeat ((TOB-2)*CPB) @(negedge clock);
    check("timeout_not_yet", state, 3'b001);
    repeat (3*CPB) @(negedge clock);
    check("timeout_expired", state, 3'b000);
    run_cmd(8'h02, 32'h0);

    // Framing error
    f0 = ferr_cnt;
    send_byte(8'h81, 1'b0);
    repeat (20*CPB) @(negedge clock);
    check("frame_err_pulses", ferr_cnt - f0, 1);
    check("frame_err_state", state, 3'b000);

    // Reset in the middle of a read reply
    run_cmd(8'h83, 32'hCAFEF00D);
    run_cmd(8'h80, 32'h0BADC0DE);
    send_cmd(8'h03, 32'h0, n);
    for (int cyc = 0; cyc < 40*CPB && tx !== 1'b0; cyc++) @(negedge clock);
    check("reply_started", tx, 1'b0);
    repeat (13*CPB) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreply_tx", tx, 1'b1);
    check("midreply_state", state, 3'b000);
    check("midreply_reg0", reg0, 32'h0);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    repeat (12*CPB) @(negedge clock);
    run_cmd(8'h03, 32'h0);

    // Randomized command mix
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 2))
        0:       c = {6'b000000, 2'($urandom_range(0, 3))};
        1:       c = {6'b100000, 2'($urandom_range(0, 3))};
        default: c = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3))};
      endcase
      run_cmd(c, $urandom);
    end
    for (int i = 0; i < 4; i++) run_cmd({6'b000000, 2'(i)}, 32'h0);

    repeat (2*CPB) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    check("cmd_done_count", done_cnt, exp_done);
    check("frame_err_count", ferr_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Device-side UART endpoint that answers the command frames a host-side arbitrator issues over its serial `rx`/`tx` pair. It receives 8N1 bytes, decodes read and write commands against a small internal 32-bit register file, and transmits the reply bytes. It sits at the far end of the serial link, standing in for the remote peripheral, and is driven directly by a UART line.

## Interface
- `CLKS_PER_BIT`, default 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `TIMEOUT_BITS`, default 40, bit times allowed between bytes of one command before the command is dropped.
- `clock` in 1: single clock; all logic updates on its rising edge.
- `reset` in 1: synchronous, active-high; overrides all other activity.
- `rx` in 1: serial input, idle high, asynchronous to `clock`.
- `tx` out 1: serial output, idle high.
- `state` out 3: current command FSM state, encoded as listed under Operation.
- `reg0` out 32: live contents of register 0.
- `cmd_done` out 1: one-cycle pulse when a command's reply has fully transmitted (last stop bit ends).
- `frame_err` out 1: one-cycle pulse when a received byte has a low stop bit.

## Operation
- **Receive path**
  - `rx` passes through a 2-flop synchronizer.
  - The receiver arms when the synchronized `rx` falls while idle.
  - The start bit is re-checked at CLKS_PER_BIT/2 cycles. If it is high, the receiver aborts back to idle with no byte.
  - Data bits are sampled LSB first, every CLKS_PER_BIT cycles after that point.
  - The stop bit is sampled one bit time after the last data bit.
  - Stop bit = 1: the byte is delivered to the FSM with a one-cycle strobe.
  - Stop bit = 0: the byte is discarded, `frame_err` pulses, and the FSM returns to IDLE.
- **Command byte**
  - bit7 = 1 means write, 0 means read.
  - bits[6:2] must be 0; any other value makes the command invalid.
  - bits[1:0] select register index 0–3.
- **FSM states**
  - IDLE=000.
  - RXDATA=001.
  - WRITE=010.
  - TXRESP=011.
  - DRAIN=100.
- **IDLE**, on a byte strobe:
  - Invalid command: load the reply 0x5A (NAK, 1 byte) and go to TXRESP.
  - Read: load the 4 bytes of reg[idx], LSB first, and go to TXRESP.
  - Write: clear the data byte counter and go to RXDATA.
- **RXDATA**
  - Each byte shifts into a 32-bit assembly register, LSB first.
  - After the 4th byte, go to WRITE.
  - The inter-byte timer counts TIMEOUT_BITS×CLKS_PER_BIT cycles and restarts on each byte strobe.
  - On expiry, go to IDLE with no reply and no register change.
- **WRITE**
  - Lasts exactly one cycle.
  - reg[idx] takes the assembled word.
  - Load the reply 0xA5 (ACK, 1 byte) and go to TXRESP.
- **TXRESP**
  - The transmitter sends the loaded bytes back-to-back as 8N1: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles long.
  - There are no idle gaps between bytes.
  - After the last stop bit, `cmd_done` pulses and the FSM goes to DRAIN.
- **DRAIN**
  - Lasts one cycle and goes to IDLE.
  - Guarantees `tx` is high for at least one cycle between replies.
- **Bytes arriving outside IDLE/RXDATA**
  - The receiver still frames them, but they are ignored; no queueing.
  - `frame_err` still pulses on a bad stop bit in any state.

## Timing
- **Reset values**
  - `tx`=1, `state`=000, all registers 0, `reg0`=0.
  - `cmd_done`=0, `frame_err`=0.
  - Receiver, transmitter and timers are idle and cleared.
- **Reset asserted mid-frame or mid-reply**
  - `tx` goes high on the next edge; a truncated frame on the line is acceptable.
  - Register contents are cleared.
- **Receive latency**
  - The byte strobe is asserted the cycle after the stop-bit sample.
  - The rx line-to-sample delay includes the 2 synchronizer cycles.
- **Reply start**
  - Read or invalid command: `tx` falls 2 cycles after the byte strobe (strobe → TXRESP → start bit driven).
  - Write: `tx` falls 3 cycles after the 4th data byte's strobe, because the WRITE cycle is in between.
- **Register update and output**
  - `reg0` reflects a write on the cycle after WRITE.
- **Reply duration**
  - 1-byte reply: 10×CLKS_PER_BIT cycles.
  - 4-byte reply: 40×CLKS_PER_BIT cycles.
  - `cmd_done` is high on the final cycle of the last stop bit.
- **Timeout boundary**
  - A byte whose strobe occurs on the same cycle the timer expires is accepted; the strobe wins.
- **Read/write interaction**
  - Reading a register in the same command sequence right after writing it returns the new value.

## Test plan
Benches use CLKS_PER_BIT=8 and TIMEOUT_BITS=40.

1. Reset: hold `reset` high for 3 cycles → `tx`=1, `state`=000, `reg0`=0. Then read reg0 (0x00) → reply bytes 00 00 00 00.
2. Write then read: send 0x81, 0xEF, 0xBE, 0xAD, 0xDE → ACK 0xA5, `cmd_done` pulse. Then send 0x01 → reply EF BE AD DE. Write to index 0 with 0x11223344 → `reg0`=0x11223344 one cycle after WRITE.
3. Invalid command: send 0x04 → NAK 0x5A, `state` returns to 000, registers unchanged.
4. Timeout: send 0x82, 0x01, then idle for 41 bit times → `state`=000, no `tx` activity, reg2 still 0. A following 0x02 returns 00 00 00 00.
5. Framing error: send 0x81 with stop bit 0 → `frame_err` pulses once, `state`=000, no reply.
6. Reset mid-reply: assert `reset` during the 2nd byte of a read reply → `tx`=1 next cycle, `state`=000, all registers 0.
